// File: rtl/dice_turn_ctrl_pkg.sv
// Shared types and constants for the two-player dice turn controller.
package dice_pkg;

  localparam int unsigned DIE_W = 4;
  localparam logic [DIE_W-1:0] DIE_MIN = 4'd1;
  localparam logic [DIE_W-1:0] DIE_MAX = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLLING = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic logic die_in_range(input logic [DIE_W-1:0] v);
    return (v >= DIE_MIN) && (v <= DIE_MAX);
  endfunction

endpackage

// File: rtl/dice_turn_ctrl_roll_timer.sv
// Saturating roll-length counter: start loads 1, run counts up to MIN_ROLL_CYCLES.
module roll_timer #(
  parameter int unsigned MIN_ROLL_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic start_i,
  input  logic run_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(MIN_ROLL_CYCLES + 1);
  localparam logic [CW-1:0] MIN_L = CW'(MIN_ROLL_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = CW'(1);
    end else if (run_i && (cnt_q < MIN_L)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q >= MIN_L);

endmodule

// File: rtl/dice_turn_ctrl.sv
// Two-player turn sequencer: grants the die, times the roll, scores the face
// value, alternates turns and latches the winner.
module dice_turn_ctrl
  import dice_pkg::*;
#(
  parameter int unsigned MIN_ROLL_CYCLES = 8,
  parameter int unsigned WIN_SCORE       = 20,
  parameter int unsigned SCORE_W         = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic [1:0]         req,
  input  logic [DIE_W-1:0]   die_value,
  output logic               die_roll,
  output logic               turn,
  output logic               result_valid,
  output logic [DIE_W-1:0]   result_value,
  output logic [SCORE_W-1:0] p0_score,
  output logic [SCORE_W-1:0] p1_score,
  output logic               winner_valid,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_L = SCORE_W'(WIN_SCORE);

  state_e             state_q;
  logic               die_roll_q;
  logic               turn_q;
  logic               result_valid_q;
  logic [DIE_W-1:0]   result_value_q;
  logic [SCORE_W-1:0] p0_q;
  logic [SCORE_W-1:0] p1_q;
  logic               winner_valid_q;
  logic               winner_q;

  logic               req_cur;
  logic               timer_start;
  logic               timer_run;
  logic               timer_done;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] add_val;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] score_d;

  // Only the granted player's button matters; the other is never queued.
  always_comb begin
    req_cur     = req[turn_q];
    timer_start = (state_q == ST_IDLE) && req_cur;
    timer_run   = (state_q == ST_ROLLING);
    cur_score   = turn_q ? p1_q : p0_q;
    add_val     = die_in_range(die_value) ? SCORE_W'(die_value) : '0;
    sum         = {1'b0, cur_score} + {1'b0, add_val};
    score_d     = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end

  roll_timer #(
    .MIN_ROLL_CYCLES(MIN_ROLL_CYCLES)
  ) u_roll_timer (
    .clock  (clock),
    .reset  (reset),
    .clear_i(new_game),
    .start_i(timer_start),
    .run_i  (timer_run),
    .done_o (timer_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      die_roll_q     <= 1'b0;
      turn_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_value_q <= '0;
      p0_q           <= '0;
      p1_q           <= '0;
      winner_valid_q <= 1'b0;
      winner_q       <= 1'b0;
    end else if (new_game) begin
      state_q        <= ST_IDLE;
      die_roll_q     <= 1'b0;
      turn_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_value_q <= '0;
      p0_q           <= '0;
      p1_q           <= '0;
      winner_valid_q <= 1'b0;
      winner_q       <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_cur) begin
            state_q    <= ST_ROLLING;
            die_roll_q <= 1'b1;
          end
        end
        ST_ROLLING: begin
          if (!req_cur && timer_done) begin
            state_q    <= ST_SETTLE;
            die_roll_q <= 1'b0;
          end
        end
        ST_SETTLE: begin
          result_value_q <= die_value;
          result_valid_q <= 1'b1;
          if (turn_q) begin
            p1_q <= score_d;
          end else begin
            p0_q <= score_d;
          end
          // Turn toggles here, so a button held through SETTLE cannot re-roll.
          if (score_d >= WIN_L) begin
            state_q        <= ST_DONE;
            winner_valid_q <= 1'b1;
            winner_q       <= turn_q;
          end else begin
            state_q <= ST_IDLE;
            turn_q  <= ~turn_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign die_roll     = die_roll_q;
  assign turn         = turn_q;
  assign result_valid = result_valid_q;
  assign result_value = result_value_q;
  assign p0_score     = p0_q;
  assign p1_score     = p1_q;
  assign winner_valid = winner_valid_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// Directed, table-driven bench for dice_turn_ctrl (MIN_ROLL_CYCLES=4, WIN_SCORE=10).
module tb_dice_turn_ctrl;

  logic       clk;
  logic       rst_n;
  logic       new_game;
  logic [1:0] req;
  logic [3:0] die_value;
  logic       die_roll;
  logic       turn;
  logic       result_valid;
  logic [3:0] result_value;
  logic [5:0] p0_score;
  logic [5:0] p1_score;
  logic       winner_valid;
  logic       winner;

  int checks = 0;
  int errors = 0;

  dice_turn_ctrl #(
    .MIN_ROLL_CYCLES(4),
    .WIN_SCORE      (10),
    .SCORE_W        (6)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .new_game    (new_game),
    .req         (req),
    .die_value   (die_value),
    .die_roll    (die_roll),
    .turn        (turn),
    .result_valid(result_valid),
    .result_value(result_value),
    .p0_score    (p0_score),
    .p1_score    (p1_score),
    .winner_valid(winner_valid),
    .winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rq;
    int         press;
    logic [3:0] dv;
    int         exp_rolls;
    int         exp_valids;
    logic [3:0] exp_rv;
    logic [5:0] exp_p0;
    logic [5:0] exp_p1;
    logic       exp_turn;
    logic       exp_wv;
    logic       exp_w;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Press req for 'press' cycles, release, then watch a fixed 20-cycle tail.
  task automatic run_turn(input logic [1:0] rq, input int press, input logic [3:0] dv,
                          output int rolls, output int valids, output int lat);
    int k;
    int last_roll;
    int valid_at;
    k = 0; rolls = 0; valids = 0; last_roll = -100; valid_at = -100;
    die_value = dv;
    req = rq;
    for (int i = 0; i < press + 20; i++) begin
      if (i == press) req = 2'b00;
      @(negedge clk);
      k++;
      if (die_roll === 1'b1) begin rolls++; last_roll = k; end
      if (result_valid === 1'b1) begin valids++; valid_at = k; end
    end
    lat = valid_at - last_roll;
  endtask

  initial begin
    int rolls, valids, lat, rv_cnt;
    string tag;

    vecs[0] = '{2'b01, 1,  4'd5, 4, 1, 4'd5, 6'd5,  6'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 10, 4'd2, 0, 0, 4'd5, 6'd5,  6'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 6,  4'd3, 6, 1, 4'd3, 6'd5,  6'd3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 1,  4'd0, 4, 1, 4'd0, 6'd5,  6'd3, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 1,  4'd7, 4, 1, 4'd7, 6'd5,  6'd3, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 2,  4'd1, 4, 1, 4'd1, 6'd6,  6'd3, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 5,  4'd2, 5, 1, 4'd2, 6'd6,  6'd5, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 1,  4'd4, 4, 1, 4'd4, 6'd10, 6'd5, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{2'b11, 10, 4'd6, 0, 0, 4'd4, 6'd10, 6'd5, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b1; new_game = 1'b0; req = 2'b01; die_value = 4'd5;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_die_roll", die_roll, 0);
    chk("reset_turn", turn, 0);
    chk("reset_p0", p0_score, 0);
    chk("reset_p1", p1_score, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_value", result_value, 0);
    chk("reset_winner_valid", winner_valid, 0);
    chk("reset_winner", winner, 0);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      run_turn(vecs[v].rq, vecs[v].press, vecs[v].dv, rolls, valids, lat);
      tag = $sformatf("v%0d", v);
      chk({tag, "_rolls"}, rolls, vecs[v].exp_rolls);
      chk({tag, "_valids"}, valids, vecs[v].exp_valids);
      if (vecs[v].exp_valids == 1) chk({tag, "_latency"}, lat, 2);
      chk({tag, "_result_value"}, result_value, vecs[v].exp_rv);
      chk({tag, "_p0"}, p0_score, vecs[v].exp_p0);
      chk({tag, "_p1"}, p1_score, vecs[v].exp_p1);
      chk({tag, "_turn"}, turn, vecs[v].exp_turn);
      chk({tag, "_winner_valid"}, winner_valid, vecs[v].exp_wv);
      chk({tag, "_winner"}, winner, vecs[v].exp_w);
    end

    // new_game out of DONE clears everything
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_p0", p0_score, 0);
    chk("ng_p1", p1_score, 0);
    chk("ng_turn", turn, 0);
    chk("ng_winner_valid", winner_valid, 0);
    chk("ng_result_value", result_value, 0);

    // new_game in the middle of a roll
    die_value = 4'd6;
    req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("midroll_rolling", die_roll, 1);
    new_game = 1'b1;
    @(negedge clk);
    chk("midroll_drop", die_roll, 0);
    new_game = 1'b0;
    req = 2'b00;
    rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1 || die_roll === 1'b1) rv_cnt++;
    end
    chk("midroll_no_activity", rv_cnt, 0);
    chk("midroll_p0", p0_score, 0);
    chk("midroll_turn", turn, 0);

    // asynchronous reset mid-roll, with scores already non-zero
    run_turn(2'b01, 1, 4'd6, rolls, valids, lat);
    chk("pre_reset_p0", p0_score, 6);
    chk("pre_reset_turn", turn, 1);
    req = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_rolling", die_roll, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_die_roll", die_roll, 0);
    chk("async_p0", p0_score, 0);
    chk("async_turn", turn, 0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
